// File: rtl/qbu_pkg.sv
// Shared types and constants for the frame-preemption transmit arbiter.
package qbu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXP,
    ST_PRE,
    ST_IFG,
    ST_HOLD
  } state_t;

  localparam logic [1:0] SMD_E = 2'd0;
  localparam logic [1:0] SMD_S = 2'd1;
  localparam logic [1:0] SMD_C = 2'd2;

  localparam int DEF_MIN_FRAG   = 60;
  localparam int DEF_IFG_CYCLES = 12;

endpackage

// File: rtl/qbu_ifg_timer.sv
// Inter-frame gap down-counter: load starts a gap, done is high while the count sits at zero.
module qbu_ifg_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] remaining;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (count && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/qbu_tx_arbiter.sv
// Express/preemptable transmit arbiter with IFG insertion and pMAC fragmentation.
// Preemption is compiled in only when QBU_PREEMPT_EN is defined; otherwise strict priority at frame boundaries.
module qbu_tx_arbiter
  import qbu_pkg::*;
#(
  parameter int IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int MIN_FRAG   = DEF_MIN_FRAG
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_e_axis_data,
  input  logic [15:0] i_e_axis_user,
  input  logic        i_e_axis_last,
  input  logic        i_e_axis_valid,
  output logic        o_e_axis_ready,
  input  logic [7:0]  i_p_axis_data,
  input  logic [15:0] i_p_axis_user,
  input  logic        i_p_axis_last,
  input  logic        i_p_axis_valid,
  output logic        o_p_axis_ready,
  output logic [7:0]  o_tx_axis_data,
  output logic        o_tx_axis_last,
  output logic        o_tx_axis_valid,
  input  logic        i_tx_axis_ready,
  output logic [1:0]  o_tx_smd,
  output logic [1:0]  o_tx_frag_cnt,
  output logic        o_tx_mcrc,
  output logic [15:0] o_preempt_cnt
);

  localparam int               IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD   = IFG_W'(IFG_CYCLES - 1);
  localparam logic [15:0]      MIN_FRAG_W = 16'(MIN_FRAG);

  state_t      state;
  logic [1:0]  smd;
  logic [1:0]  frag_cnt;
  logic [15:0] p_sent;
  logic        resume_pending;

  logic e_grant;
  logic p_grant;
  logic e_xfer;
  logic p_xfer;
  logic cut_now;
  logic to_ifg;
  logic ifg_done;

  assign e_grant = (state == ST_EXP) || (state == ST_HOLD);
  assign p_grant = (state == ST_PRE);

  assign o_e_axis_ready = e_grant && i_tx_axis_ready;
  assign o_p_axis_ready = p_grant && i_tx_axis_ready;

  assign e_xfer = e_grant && i_e_axis_valid && i_tx_axis_ready;
  assign p_xfer = p_grant && i_p_axis_valid && i_tx_axis_ready;

`ifdef QBU_PREEMPT_EN
  logic [15:0] preempt_cnt;
  logic        unused_e_user;

  // Cut only when both the sent fragment and the remainder stay at or above MIN_FRAG.
  assign cut_now = p_grant && i_p_axis_valid && i_e_axis_valid &&
                   (p_sent >= MIN_FRAG_W) && (i_p_axis_user > p_sent) &&
                   ((i_p_axis_user - p_sent) > MIN_FRAG_W);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      preempt_cnt <= '0;
    end else if (p_xfer && cut_now && (preempt_cnt != 16'hFFFF)) begin
      preempt_cnt <= preempt_cnt + 16'd1;
    end
  end

  assign o_preempt_cnt = preempt_cnt;
  assign o_tx_mcrc     = cut_now;
  assign unused_e_user = ^i_e_axis_user;
`else
  logic unused_users;

  assign cut_now       = 1'b0;
  assign o_preempt_cnt = 16'd0;
  assign o_tx_mcrc     = 1'b0;
  assign unused_users  = ^{i_e_axis_user, i_p_axis_user};
`endif

  assign to_ifg = (e_xfer && i_e_axis_last) || (p_xfer && (i_p_axis_last || cut_now));

  always_comb begin
    o_tx_axis_data  = '0;
    o_tx_axis_valid = 1'b0;
    o_tx_axis_last  = 1'b0;
    if (e_grant) begin
      o_tx_axis_data  = i_e_axis_data;
      o_tx_axis_valid = i_e_axis_valid;
      o_tx_axis_last  = i_e_axis_last;
    end else if (p_grant) begin
      o_tx_axis_data  = i_p_axis_data;
      o_tx_axis_valid = i_p_axis_valid;
      o_tx_axis_last  = i_p_axis_last || cut_now;
    end
  end

  assign o_tx_smd      = smd;
  assign o_tx_frag_cnt = frag_cnt;

  qbu_ifg_timer #(
    .WIDTH(IFG_W)
  ) u_ifg_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (to_ifg),
    .load_val(IFG_LOAD),
    .count   (state == ST_IFG),
    .done    (ifg_done)
  );

  // HOLD serves express while a cut pMAC frame waits to resume after the next gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      smd            <= SMD_E;
      frag_cnt       <= '0;
      p_sent         <= '0;
      resume_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_e_axis_valid) begin
            state <= ST_EXP;
            smd   <= SMD_E;
          end else if (i_p_axis_valid) begin
            state    <= ST_PRE;
            smd      <= SMD_S;
            frag_cnt <= '0;
          end
        end
        ST_EXP, ST_HOLD: begin
          if (e_xfer && i_e_axis_last) state <= ST_IFG;
        end
        ST_PRE: begin
          if (p_xfer) begin
            if (i_p_axis_last) begin
              p_sent <= '0;
              state  <= ST_IFG;
            end else begin
              p_sent <= p_sent + 16'd1;
              if (cut_now) begin
                state          <= ST_IFG;
                resume_pending <= 1'b1;
              end
            end
          end
        end
        ST_IFG: begin
          if (ifg_done) begin
            if (i_e_axis_valid) begin
              state <= resume_pending ? ST_HOLD : ST_EXP;
              smd   <= SMD_E;
            end else if (resume_pending) begin
              state          <= ST_PRE;
              smd            <= SMD_C;
              frag_cnt       <= frag_cnt + 2'd1;
              resume_pending <= 1'b0;
            end else if (i_p_axis_valid) begin
              state    <= ST_PRE;
              smd      <= SMD_S;
              frag_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
